// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit for a five-stage in-order pipeline.
// Tracks the producers in the EX and MEM slots and compares them against the
// source registers of the instruction in ID. It produces registered forwarding
// selects for the consumer's EXE cycle, plus a combinational load-use stall.
module hazard_forward_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd_addr,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        stall_in,
    input  logic        flush,
    output logic        rs1_exe_hazard,
    output logic        rs1_mem_hazard,
    output logic        rs2_exe_hazard,
    output logic        rs2_mem_hazard,
    output logic        lu_stall,
    output logic [15:0] lu_stall_cnt
);

    // EX slot mirrors ID/EXE; MEM slot mirrors EXE/MEM.
    logic        ex_valid_q,  ex_valid_d;
    logic [4:0]  ex_rd_q,     ex_rd_d;
    logic        ex_wr_q,     ex_wr_d;
    logic        ex_load_q,   ex_load_d;
    logic        mem_valid_q, mem_valid_d;
    logic [4:0]  mem_rd_q,    mem_rd_d;
    logic        mem_wr_q,    mem_wr_d;

    logic        rs1_exe_q, rs1_exe_d;
    logic        rs1_mem_q, rs1_mem_d;
    logic        rs2_exe_q, rs2_exe_d;
    logic        rs2_mem_q, rs2_mem_d;
    logic [15:0] cnt_q,     cnt_d;

    logic ex_m1, ex_m2, mem_m1, mem_m2;
    logic lu_stall_c;

    // A slot feeds a source only if both are real, the producer writes the
    // register, and the register is not x0 (hardwired zero never forwards).
    function automatic logic slot_match(
        input logic       slot_valid,
        input logic       slot_wr,
        input logic [4:0] slot_rd,
        input logic       src_used,
        input logic [4:0] src_addr
    );
        return id_valid && src_used && slot_valid && slot_wr &&
               (slot_rd == src_addr) && (src_addr != 5'd0);
    endfunction

    // Source matches against both slots and the load-use stall decision.
    always_comb begin
        ex_m1  = slot_match(ex_valid_q,  ex_wr_q,  ex_rd_q,  id_rs1_used, id_rs1_addr);
        ex_m2  = slot_match(ex_valid_q,  ex_wr_q,  ex_rd_q,  id_rs2_used, id_rs2_addr);
        mem_m1 = slot_match(mem_valid_q, mem_wr_q, mem_rd_q, id_rs1_used, id_rs1_addr);
        mem_m2 = slot_match(mem_valid_q, mem_wr_q, mem_rd_q, id_rs2_used, id_rs2_addr);
        // A load still in EX has no data to forward yet, so the consumer waits.
        lu_stall_c = ex_valid_q && ex_load_q && (ex_m1 || ex_m2) && !stall_in && !flush;
    end

    // Next-state selection: stall_in > flush > load-use bubble > normal advance.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        ex_valid_d  = ex_valid_q;
        ex_rd_d     = ex_rd_q;
        ex_wr_d     = ex_wr_q;
        ex_load_d   = ex_load_q;
        mem_valid_d = mem_valid_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        rs1_exe_d   = rs1_exe_q;
        rs1_mem_d   = rs1_mem_q;
        rs2_exe_d   = rs2_exe_q;
        rs2_mem_d   = rs2_mem_q;
        cnt_d       = cnt_q;

        if (stall_in) begin
            // Whole pipeline frozen: hold everything.
        end else if (flush || lu_stall_c) begin
            // Bubble into EX, the old EX producer still retires into MEM.
            ex_valid_d  = 1'b0;
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            mem_wr_d    = ex_wr_q;
            rs1_exe_d   = 1'b0;
            rs1_mem_d   = 1'b0;
            rs2_exe_d   = 1'b0;
            rs2_mem_d   = 1'b0;
            if (lu_stall_c && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            rs1_exe_d   = ex_m1;
            rs1_mem_d   = mem_m1;
            rs2_exe_d   = ex_m2;
            rs2_mem_d   = mem_m2;
            ex_valid_d  = id_valid;
            ex_rd_d     = id_rd_addr;
            ex_wr_d     = id_reg_write;
            ex_load_d   = id_mem_read;
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            mem_wr_d    = ex_wr_q;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= 5'd0;
            ex_wr_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= 5'd0;
            mem_wr_q    <= 1'b0;
            rs1_exe_q   <= 1'b0;
            rs1_mem_q   <= 1'b0;
            rs2_exe_q   <= 1'b0;
            rs2_mem_q   <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, independent of statement order.
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_wr_q     <= ex_wr_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            rs1_exe_q   <= rs1_exe_d;
            rs1_mem_q   <= rs1_mem_d;
            rs2_exe_q   <= rs2_exe_d;
            rs2_mem_q   <= rs2_mem_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rs1_exe_hazard = rs1_exe_q;
    assign rs1_mem_hazard = rs1_mem_q;
    assign rs2_exe_hazard = rs2_exe_q;
    assign rs2_mem_hazard = rs2_mem_q;
    assign lu_stall       = lu_stall_c;
    assign lu_stall_cnt   = cnt_q;

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_rs1_addr, id_rs2_addr  input  5 each  source register numbers of the ID instruction.
REQ-006 id_rs1_used, id_rs2_used  input  1 each  ID instruction reads rs1 / rs2.
REQ-007 id_rd_addr  input  5  destination register of the ID instruction.
REQ-008 id_reg_write  input  1  ID instruction writes rd.
REQ-009 id_mem_read  input  1  ID instruction is a load.
REQ-010 stall_in  input  1  external pipeline freeze, e.g. memory wait.
REQ-011 flush  input  1  taken branch/jump; kills the ID instruction.
REQ-012 rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard  output  1 each  registered forwarding selects, valid while the consumer is in EXE.
REQ-013 lu_stall  output  1  combinational load-use stall; holds PC and IF/ID and inserts an EXE bubble.
REQ-014 lu_stall_cnt  output  16  saturating count of load-use stall cycles.

Function
REQ-015 The block SHALL track two producer slots: EX (ex_valid, ex_rd, ex_wr, ex_load) and MEM (mem_valid, mem_rd, mem_wr), mirroring the ID/EXE and EXE/MEM pipeline registers.
REQ-016 A slot match for source s SHALL require all of: id_valid, id_s_used, slot valid, slot wr, slot rd == id_s_addr, and id_s_addr != 0.
REQ-017 lu_stall SHALL be 1 when ex_valid, ex_load and the EX slot matches rs1 or rs2, AND stall_in=0, AND flush=0; otherwise 0.
REQ-018 Priority per edge SHALL be stall_in > flush > lu_stall > normal advance.
REQ-019 stall_in=1 SHALL hold all slots, the four flags and the counter unchanged.
REQ-020 flush=1 SHALL load an invalid EX slot, advance the EX slot into MEM, and clear all four flags.
REQ-021 lu_stall=1 SHALL load an invalid EX slot (bubble), advance the EX slot into MEM, clear all four flags, and increment lu_stall_cnt.
REQ-022 lu_stall_cnt SHALL saturate at 16'hFFFF.
REQ-023 On normal advance:
- rsN_exe_hazard SHALL be set from the EX-slot match of rsN.
- rsN_mem_hazard SHALL be set from the MEM-slot match of rsN.
- The EX slot SHALL be loaded from the id_* fields, with ex_valid = id_valid.
- The EX slot SHALL advance into MEM.
REQ-024 Both exe and mem flags for one source MAY be 1 simultaneously; the consumer gives exe priority.
REQ-025 Forwarding latency SHALL be one cycle: flags computed in ID are presented in the following cycle, aligned with the consumer in EXE.
REQ-026 After a load-use stall, re-evaluation of the held ID instruction SHALL produce mem_hazard=1, exe_hazard=0 for the dependent source, since the load now sits in the MEM slot.
REQ-027 Register x0 SHALL never produce a hazard or a stall.

Reset
REQ-028 With rst_n=0, the block SHALL asynchronously clear:
- ex_valid and mem_valid;
- all four hazard flags;
- lu_stall_cnt to 0.
REQ-029 lu_stall SHALL read 0 during reset and in the first cycle after release.
REQ-030 Reset asserted mid-stall SHALL abandon the stall; no partial state SHALL survive.

Verification
REQ-031 ALU back-to-back: add x5 then sub uses rs1=x5 -> next cycle rs1_exe_hazard=1, all other flags 0, lu_stall never 1.
REQ-032 Distance two: add x7, nop, then use rs2=x7 -> rs2_mem_hazard=1, rs2_exe_hazard=0.
REQ-033 Load-use: lw x3 then add with rs1=x3 ->
- lu_stall=1 for exactly one cycle and lu_stall_cnt 0->1;
- next cycle flags all 0 (bubble);
- following cycle rs1_mem_hazard=1.
REQ-034 x0 case: addi x0 then use rs1=x0, including after a load to x0 -> no flag, no stall.
REQ-035 Stall and flush:
- stall_in=1 for 3 cycles during a matching sequence -> flags and counter frozen, then resume correctly.
- flush coinciding with a load-use match -> lu_stall=0 and flags cleared.
REQ-036 Reset mid-operation: rst_n low during lu_stall -> outputs 0 immediately; preload lu_stall_cnt=16'hFFFF then apply a further stall -> count stays 16'hFFFF.
